// File: rtl/nv_blkbox_obs_pkg.sv
// Shared defaults and state encoding for the blackbox observation scheduler.
package nv_blkbox_obs_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned CW_DEF      = 8;
    localparam int unsigned CNT_W       = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_GRANT = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/nv_blkbox_rr_pick.sv
// Combinational round-robin pick: first set request after last_idx, wrapping.
module nv_blkbox_rr_pick
    import nv_blkbox_obs_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_idx,
    output logic [$clog2(NUM_REQ)-1:0] win_idx_c,
    output logic                       win_vld_c
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0] cand;

    // NUM_REQ is a power of two, so IW-bit addition wraps modulo NUM_REQ.
    always_comb begin
        win_idx_c = '0;
        win_vld_c = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = last_idx + IW'(i);
            if (!win_vld_c && req[cand]) begin
                win_vld_c = 1'b1;
                win_idx_c = cand;
            end
        end
    end

endmodule

// File: rtl/nv_blkbox_obs_sched.sv
// Round-robin observation scheduler: grants one requester, captures its data, then dwells.
module nv_blkbox_obs_sched
    import nv_blkbox_obs_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned CW      = CW_DEF
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rst,
    input  logic                       obs_en,
    input  logic [CW-1:0]              cfg_dwell,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*DW-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic                       obs_vld,
    output logic [DW-1:0]              obs_data,
    output logic [$clog2(NUM_REQ)-1:0] obs_id,
    output logic [CNT_W-1:0]           obs_cnt
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    state_t             state_q,    state_d;
    logic [IW-1:0]      gnt_idx_q,  gnt_idx_d;
    logic [IW-1:0]      last_idx_q, last_idx_d;
    logic [CW-1:0]      dwell_q,    dwell_d;
    logic [NUM_REQ-1:0] req_rdy_q,  req_rdy_d;
    logic               obs_vld_q,  obs_vld_d;
    logic [DW-1:0]      obs_data_q, obs_data_d;
    logic [IW-1:0]      obs_id_q,   obs_id_d;
    logic [CNT_W-1:0]   obs_cnt_q,  obs_cnt_d;

    logic [IW-1:0]      win_idx_c;
    logic               win_vld_c;
    logic               start_c;
    logic               hs_c;
    logic [DW-1:0]      cap_data_c;

    nv_blkbox_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req       (req_vld),
        .last_idx  (last_idx_q),
        .win_idx_c (win_idx_c),
        .win_vld_c (win_vld_c)
    );

    assign start_c    = obs_en && win_vld_c;
    assign hs_c       = (state_q == ST_GRANT) && req_vld[gnt_idx_q];
    assign cap_data_c = req_data[DW * 32'(gnt_idx_q) +: DW];

    // State and datapath registers
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IW'(NUM_REQ - 1);
            dwell_q    <= '0;
            req_rdy_q  <= '0;
            obs_vld_q  <= 1'b0;
            obs_data_q <= '0;
            obs_id_q   <= '0;
            obs_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            dwell_q    <= dwell_d;
            req_rdy_q  <= req_rdy_d;
            obs_vld_q  <= obs_vld_d;
            obs_data_q <= obs_data_d;
            obs_id_q   <= obs_id_d;
            obs_cnt_q  <= obs_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = hs_c ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (dwell_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs and datapath; req_rdy is registered from the upcoming state
    always_comb begin
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        dwell_d    = dwell_q;
        req_rdy_d  = '0;
        obs_vld_d  = 1'b0;
        obs_data_d = obs_data_q;
        obs_id_d   = obs_id_q;
        obs_cnt_d  = obs_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    gnt_idx_d = win_idx_c;
                end
            end
            ST_GRANT: begin
                last_idx_d = gnt_idx_q;
                if (hs_c) begin
                    obs_data_d = cap_data_c;
                    obs_id_d   = gnt_idx_q;
                    obs_vld_d  = 1'b1;
                    obs_cnt_d  = obs_cnt_q + CNT_W'(1);
                    dwell_d    = cfg_dwell;
                end
            end
            ST_HOLD: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - CW'(1);
                end
            end
            default: begin
            end
        endcase
        if (state_d == ST_GRANT) begin
            req_rdy_d = NUM_REQ'(1) << gnt_idx_d;
        end
    end

    assign req_rdy  = req_rdy_q;
    assign obs_vld  = obs_vld_q;
    assign obs_data = obs_data_q;
    assign obs_id   = obs_id_q;
    assign obs_cnt  = obs_cnt_q;

endmodule

// File: tb/tb_nv_blkbox_obs_sched.sv
// Directed table-driven bench for nv_blkbox_obs_sched plus reset and counter-wrap sequences.
module tb_nv_blkbox_obs_sched;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  dwell;
        logic [3:0]  vld;
        logic [3:0]  rdy;
        logic        ovld;
        logic [1:0]  id;
        logic [31:0] data;
        logic [15:0] cnt;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         obs_en;
    logic [7:0]   cfg_dwell;
    logic [3:0]   req_vld;
    logic [127:0] req_data;
    logic [3:0]   req_rdy;
    logic         obs_vld;
    logic [31:0]  obs_data;
    logic [1:0]   obs_id;
    logic [15:0]  obs_cnt;

    int checks;
    int failures;
    vec_t tbl[$];

    nv_blkbox_obs_sched dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .obs_en         (obs_en),
        .cfg_dwell      (cfg_dwell),
        .req_vld        (req_vld),
        .req_data       (req_data),
        .req_rdy        (req_rdy),
        .obs_vld        (obs_vld),
        .obs_data       (obs_data),
        .obs_id         (obs_id),
        .obs_cnt        (obs_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input int i);
        return 32'hA5A5_0001 + 32'(i);
    endfunction

    function automatic void add(input logic r, input logic e, input logic [7:0] dw,
                                input logic [3:0] v, input logic [3:0] rd, input logic ov,
                                input logic [1:0] id, input logic [31:0] d, input logic [15:0] c);
        vec_t x;
        x.rst = r; x.en = e; x.dwell = dw; x.vld = v;
        x.rdy = rd; x.ovld = ov; x.id = id; x.data = d; x.cnt = c;
        tbl.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] rd, input logic ov,
                           input logic [1:0] id, input logic [31:0] d, input logic [15:0] c);
        chk({tag, ".req_rdy"},  64'(req_rdy),  64'(rd));
        chk({tag, ".obs_vld"},  64'(obs_vld),  64'(ov));
        chk({tag, ".obs_id"},   64'(obs_id),   64'(id));
        chk({tag, ".obs_data"}, 64'(obs_data), 64'(d));
        chk({tag, ".obs_cnt"},  64'(obs_cnt),  64'(c));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        obs_en    = 1'b0;
        cfg_dwell = 8'd0;
        req_vld   = 4'b0000;
        req_data  = {dat(3), dat(2), dat(1), dat(0)};

        // Reset state, then single requester 0: rdy at +1, obs_vld at +2
        add(1, 0, 0, 4'b0000, 4'b0000, 0, 0, 32'h0, 0);
        add(0, 1, 0, 4'b0001, 4'b0001, 0, 0, 32'h0, 0);
        add(0, 1, 0, 4'b0001, 4'b0000, 1, 0, dat(0), 1);
        add(0, 1, 0, 4'b0000, 4'b0000, 0, 0, dat(0), 1);
        add(0, 1, 0, 4'b0000, 4'b0000, 0, 0, dat(0), 1);

        // Fairness: all four requesting, dwell=2 -> order 0,1,2,3,0 every 5 cycles
        add(1, 0, 0, 4'b0000, 4'b0000, 0, 0, 32'h0, 0);
        for (int k = 0; k < 5; k++) begin
            int idx;
            int pid;
            idx = k % 4;
            pid = (k == 0) ? 0 : (k - 1) % 4;
            add(0, 1, 2, 4'b1111, 4'(1 << idx), 0, 2'(pid),
                (k == 0) ? 32'h0 : dat(pid), 16'(k));
            add(0, 1, 2, 4'b1111, 4'b0000, 1, 2'(idx), dat(idx), 16'(k + 1));
            for (int h = 0; h < 3; h++)
                add(0, 1, 2, 4'b1111, 4'b0000, 0, 2'(idx), dat(idx), 16'(k + 1));
        end

        // Withdraw: requester 2 drops in its GRANT cycle, then {1,2} searched from 3 -> 1
        add(1, 0, 0, 4'b0000, 4'b0000, 0, 0, 32'h0, 0);
        add(0, 1, 0, 4'b0100, 4'b0100, 0, 0, 32'h0, 0);
        add(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 32'h0, 0);
        add(0, 1, 0, 4'b0110, 4'b0010, 0, 0, 32'h0, 0);
        add(0, 1, 0, 4'b0110, 4'b0000, 1, 1, dat(1), 1);

        // Enable gating: 20 cycles blocked, then grant to 2
        add(1, 0, 0, 4'b0000, 4'b0000, 0, 0, 32'h0, 0);
        for (int k = 0; k < 20; k++)
            add(0, 0, 0, 4'b0100, 4'b0000, 0, 0, 32'h0, 0);
        add(0, 1, 0, 4'b0100, 4'b0100, 0, 0, 32'h0, 0);
        add(0, 1, 0, 4'b0100, 4'b0000, 1, 2, dat(2), 1);

        step();
        foreach (tbl[i]) begin
            rst       = tbl[i].rst;
            obs_en    = tbl[i].en;
            cfg_dwell = tbl[i].dwell;
            req_vld   = tbl[i].vld;
            step();
            chk_all($sformatf("row%0d", i), tbl[i].rdy, tbl[i].ovld, tbl[i].id,
                    tbl[i].data, tbl[i].cnt);
        end

        // Reset during GRANT: no capture, no pulse
        rst = 1'b1; obs_en = 1'b0; req_vld = 4'b0000; step();
        rst = 1'b0; obs_en = 1'b1; cfg_dwell = 8'd0; req_vld = 4'b0001; step();
        chk("grant_rst.pre_rdy", 64'(req_rdy), 64'(4'b0001));
        rst = 1'b1; step();
        chk_all("grant_rst", 4'b0000, 0, 0, 32'h0, 0);

        // Reset during a long HOLD, then the first grant goes to 0
        rst = 1'b0; obs_en = 1'b1; cfg_dwell = 8'hFF; req_vld = 4'b0001; step();
        step();
        chk("hold_rst.capture", 64'(obs_vld), 64'(1));
        req_vld = 4'b0000; step(); step();
        chk("hold_rst.in_hold", 64'(dut.state_q), 64'(2'd2));
        rst = 1'b1; step();
        chk_all("hold_rst", 4'b0000, 0, 0, 32'h0, 0);
        chk("hold_rst.state", 64'(dut.state_q), 64'(2'd0));
        rst = 1'b0; req_vld = 4'b1111; cfg_dwell = 8'd0; step();
        chk("hold_rst.first_grant", 64'(req_rdy), 64'(4'b0001));

        // Counter wrap from 16'hFFFF
        rst = 1'b1; req_vld = 4'b0000; step();
        rst = 1'b0; obs_en = 1'b1; cfg_dwell = 8'd0; step();
        force dut.obs_cnt_q = 16'hFFFF;
        step();
        release dut.obs_cnt_q;
        chk("wrap.preload", 64'(obs_cnt), 64'(16'hFFFF));
        req_vld = 4'b0010; step();
        chk("wrap.rdy", 64'(req_rdy), 64'(4'b0010));
        step();
        chk_all("wrap", 4'b0000, 1, 1, dat(1), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nv_blkbox_obs_sched.md
NV_BLKBOX_OBS_SCHED -- requirements
Module: nv_blkbox_obs_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of spare/blackbox observation requesters (power of 2, 2..8).
REQ-002 Parameter DW, default 32, SHALL set the observation data width.
REQ-003 Parameter CW, default 8, SHALL set the dwell counter width.
REQ-004 nvdla_core_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 nvdla_core_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 obs_en  input  1  SHALL enable new arbitration rounds.
REQ-007 cfg_dwell  input  CW  SHALL set the number of extra HOLD cycles after each capture.
REQ-008 req_vld  input  NUM_REQ  SHALL be the per-requester valid.
REQ-009 req_data  input  NUM_REQ*DW  SHALL be the packed per-requester data; requester i occupies slice i.
REQ-010 req_rdy  output  NUM_REQ  SHALL be the one-hot (or zero) per-requester ready.
REQ-011 obs_vld  output  1  SHALL be a one-cycle pulse marking new obs_data/obs_id.
REQ-012 obs_data  output  DW  SHALL be the last captured data.
REQ-013 obs_id  output  log2(NUM_REQ)  SHALL be the index of the last captured requester.
REQ-014 obs_cnt  output  16  SHALL be the count of completed captures.

Function
REQ-015 FSM SHALL have states IDLE, GRANT, HOLD.
REQ-016 IDLE: with obs_en=1 and req_vld!=0, the FSM SHALL register the round-robin winner (search starts at last_idx+1, wrapping modulo NUM_REQ) into gnt_idx and move to GRANT. Otherwise it SHALL stay in IDLE.
REQ-017 GRANT: req_rdy[gnt_idx] SHALL be 1 and all other bits 0. req_rdy SHALL be 0 in IDLE and HOLD.
REQ-018 GRANT with req_vld[gnt_idx]=1 (handshake) SHALL do all of the following: capture req_data slice into obs_data; set obs_id=gnt_idx; pulse obs_vld next cycle; increment obs_cnt; load dwell counter with cfg_dwell; go to HOLD.
REQ-019 GRANT with req_vld[gnt_idx]=0 (withdrawn) SHALL capture nothing and return to IDLE.
REQ-020 last_idx SHALL update to gnt_idx on every GRANT exit, handshake or withdrawn.
REQ-021 HOLD SHALL decrement the dwell counter each cycle and exit to IDLE in the cycle it reads 0; cfg_dwell=0 gives exactly 1 HOLD cycle.
REQ-022 cfg_dwell SHALL be sampled only at the counter load.
REQ-023 Minimum latency SHALL be: req_vld rise in IDLE -> req_rdy at cycle +1; obs_vld at cycle +2. Back-to-back capture period SHALL be cfg_dwell+3 cycles.
REQ-024 obs_en deasserting SHALL block only the IDLE->GRANT transition; GRANT and HOLD SHALL complete normally.
REQ-025 obs_cnt SHALL wrap from 16'hFFFF to 0.
REQ-026 Simultaneous requests SHALL be served strictly round-robin with no requester starved.

Reset
REQ-027 While nvdla_core_rst=1 at a clock edge, the block SHALL force: state=IDLE, gnt_idx=0, last_idx=NUM_REQ-1 (so requester 0 wins first), dwell counter=0, req_rdy=0, obs_vld=0, obs_data=0, obs_id=0, obs_cnt=0.
REQ-028 Reset asserted mid-GRANT or mid-HOLD SHALL abort without capture and without an obs_vld pulse.

Structure
REQ-029 State encoding localparams and the NUM_REQ/DW/CW defaults SHALL live in shared package nv_blkbox_obs_pkg.
REQ-030 The round-robin winner search SHALL be a sub-module nv_blkbox_rr_pick (inputs: request vector and last_idx; output: winner index plus any flag); it SHALL be purely combinational.

Verification
REQ-031 Reset check: after reset, req_vld=4'b0001, data0=32'hA5A5_0001, obs_en=1 -> req_rdy=0001 one cycle later; obs_vld with obs_data=32'hA5A5_0001, obs_id=0 the next cycle; obs_cnt=1.
REQ-032 Fairness: req_vld=4'b1111 held, cfg_dwell=2 -> capture order 0,1,2,3,0; obs_vld period 5 cycles.
REQ-033 Withdraw: requester 2 alone, req_vld dropped in its GRANT cycle -> no obs_vld and obs_cnt unchanged; the next request from 1 and 2 grants 3-wrap-aware (winner 0..1 search order from 3) -> 1.
REQ-034 Enable gating: obs_en=0 with req_vld=4'b0100 -> req_rdy stays 0 for 20 cycles; obs_en=1 -> grant to 2 the next cycle.
REQ-035 Reset mid-HOLD with cfg_dwell=8'hFF -> next cycle state IDLE and all outputs 0; the first post-reset grant goes to requester 0.
REQ-036 Wrap: obs_cnt preloaded by forcing it to 16'hFFFF, then one capture -> obs_cnt=0.
